result_log_ctrl: RTL and testbench
==================================

Name: result_log_ctrl

Overview:
Controller that sits directly upstream of the calculator's result memory (synchronous RAM: din/addr/RW/valid/dout, registered read, dout forced to 0 when valid is low). It accepts ALU results over a valid/ready handshake and stores them as a circular history log. It serves read-back requests indexed relative to the newest entry, and absorbs the memory's one-cycle read latency. All memory-side outputs are registered.

Parameters:
WIDTH, 32, data width; must match the memory data width.
DEPTH, 8, address width; the log holds 2^DEPTH entries.

Ports:
clk  input  1  clock
reset  input  1  async active-high reset
wr_req  input  1  result valid from ALU
wr_data  input  WIDTH  result to log
wr_ready  output  1  write accepted when wr_req && wr_ready at posedge
rd_req  input  1  read-back request
rd_index  input  DEPTH  0 = newest entry, k = k-th older entry
rd_ready  output  1  read accepted when rd_req && rd_ready at posedge
rd_data  output  WIDTH  read-back data
rd_valid  output  1  one-cycle pulse qualifying rd_data/rd_err
rd_err  output  1  rd_index >= count; rd_data = 0
clr  input  1  empty the log (pointers only, memory untouched)
count  output  DEPTH+1  number of valid entries, saturates at 2^DEPTH
full  output  1  count == 2^DEPTH
mem_din  output  WIDTH  to memory din
mem_addr  output  DEPTH  to memory addr
mem_rw  output  1  1 = write, 0 = read
mem_valid  output  1  to memory valid
mem_dout  input  WIDTH  from memory dout

Behaviour:
- Reset is async, active-high: the clk/reset domain uses async active-high reset on clk. state=IDLE; wr_ptr=0; count=0; mem_valid=0, mem_rw=0, mem_addr=0, mem_din=0; rd_data=0, rd_valid=0, rd_err=0. Reset mid-operation aborts the operation; no rd_valid pulse follows.
- States: IDLE, WR, RD_ISSUE, RD_WAIT.
- Handshake, combinational from state and inputs:
  - wr_ready = IDLE && !clr.
  - rd_ready = IDLE && !clr && !wr_req.
  - Priority in IDLE: clr > write > read.
- clr in IDLE: wr_ptr<=0, count<=0. clr is ignored outside IDLE.
- Write accepted at edge N:
  - At N: mem_valid<=1, mem_rw<=1, mem_addr<=wr_ptr, mem_din<=wr_data; IDLE->WR.
  - At N+1: memory stores the entry. mem_valid<=0; wr_ptr<=wr_ptr+1 (mod 2^DEPTH); count<=count+1 unless full; WR->IDLE.
  - Throughput is one write per 2 cycles.
  - Write when full overwrites the oldest entry; count stays at 2^DEPTH.
- Read accepted at edge N:
  - phys = (wr_ptr-1-rd_index) mod 2^DEPTH.
  - At N: if rd_index < count: mem_valid<=1, mem_rw<=0, mem_addr<=phys. Otherwise mem_valid stays 0 and err_q<=1. IDLE->RD_ISSUE.
  - At N+1: memory registers dout. mem_valid<=0; RD_ISSUE->RD_WAIT.
  - At N+2: rd_data<=(err_q ? 0 : mem_dout); rd_err<=err_q; rd_valid<=1; RD_WAIT->IDLE.
  - At N+3: rd_valid<=0, rd_err<=0; rd_data holds its value.
- mem_rw returns to 0 whenever mem_valid deasserts. mem_din/mem_addr hold their last values.
- A write and a read are never in flight together. While not IDLE both ready signals are 0, and requests are held by the requester.
- count and full are registered. full is derived from count.

Decomposition:
- Package calc_mem_pkg:
  - state enum log_state_t {IDLE, WR, RD_ISSUE, RD_WAIT};
  - localparams for default WIDTH/DEPTH;
  - function computing phys address from wr_ptr and rd_index.
- No sub-module. Pointer/count logic is small enough to stay inline. The memory is instantiated by the parent, not inside this block.

Test Plan:
1. Reset, then write 0x0000_000A, 0x0000_000B, 0x0000_000C -> mem writes at addr 0,1,2 at edges N+1; count=3, wr_ready low exactly one cycle after each accept.
2. After test 1, rd_index=0 -> rd_valid pulse 2 cycles after accept with rd_data=0x0000_000C; rd_index=2 -> rd_data=0x0000_000A; rd_err=0 in both.
3. After test 1, rd_index=5 -> rd_err=1, rd_data=0, mem_valid never asserted during that read.
4. DEPTH=2: write 1,2,3,4,5 -> full=1 after 4th write, count=4, 5th write goes to addr 0; rd_index=3 returns 2 (oldest surviving).
5. wr_req, rd_req and clr asserted together in IDLE -> only clr takes effect, count=0, wr_ready=rd_ready=0 that cycle. Next cycle, with clr low: wr_req and rd_req together -> write accepted, read waits.
6. Assert reset in RD_ISSUE -> state=IDLE, mem_valid=0, no rd_valid pulse; count=0 afterwards.

Source files
------------

// File: rtl/calc_mem_pkg.sv
// Shared types and helpers for the result log controller.
// Holds the FSM state enum, default sizes and log address math.
package calc_mem_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_WAIT
  } log_state_t;

  // Newest entry sits at wr_ptr-1; callers truncate to DEPTH bits,
  // which gives the wrap-around for free.
  function automatic logic [31:0] phys_addr(
    input logic [31:0] wr_ptr,
    input logic [31:0] idx
  );
    return wr_ptr - 32'd1 - idx;
  endfunction

endpackage

// File: rtl/result_log_ctrl.sv
// Circular history log controller in front of the result RAM.
// Ports: wr_* (ALU handshake), rd_* (read-back), clr, count/full,
// mem_* (registered RAM side, one-cycle registered read data).
module result_log_ctrl
  import calc_mem_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             rd_req,
  input  logic [DEPTH-1:0] rd_index,
  output logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             rd_err,
  input  logic             clr,
  output logic [DEPTH:0]   count,
  output logic             full,
  output logic [WIDTH-1:0] mem_din,
  output logic [DEPTH-1:0] mem_addr,
  output logic             mem_rw,
  output logic             mem_valid,
  input  logic [WIDTH-1:0] mem_dout
);

  localparam logic [DEPTH:0] FULL_CNT = (DEPTH+1)'(1) << DEPTH;

  log_state_t       state_q;
  logic [DEPTH-1:0] wr_ptr_q;
  logic [DEPTH:0]   count_q;
  logic             err_q;

  logic [DEPTH-1:0] phys_d;
  logic             hit_d;
  logic [DEPTH:0]   count_d;

  assign wr_ready = (state_q == IDLE) && !clr;
  assign rd_ready = (state_q == IDLE) && !clr && !wr_req;
  assign count    = count_q;
  assign full     = (count_q == FULL_CNT);

  assign phys_d  = DEPTH'(phys_addr(32'(wr_ptr_q), 32'(rd_index)));
  assign hit_d   = ({1'b0, rd_index} < count_q);
  // Saturate: once full, a write replaces the oldest entry.
  assign count_d = full ? count_q : count_q + (DEPTH+1)'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      mem_valid <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      rd_err    <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (clr) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
          end else if (wr_req) begin
            mem_valid <= 1'b1;
            mem_rw    <= 1'b1;
            mem_addr  <= wr_ptr_q;
            mem_din   <= wr_data;
            state_q   <= WR;
          end else if (rd_req) begin
            // Out-of-range reads never touch the RAM.
            if (hit_d) begin
              mem_valid <= 1'b1;
              mem_rw    <= 1'b0;
              mem_addr  <= phys_d;
            end
            err_q   <= !hit_d;
            state_q <= RD_ISSUE;
          end
        end
        WR: begin
          mem_valid <= 1'b0;
          mem_rw    <= 1'b0;
          wr_ptr_q  <= wr_ptr_q + DEPTH'(1);
          count_q   <= count_d;
          state_q   <= IDLE;
        end
        RD_ISSUE: begin
          mem_valid <= 1'b0;
          mem_rw    <= 1'b0;
          state_q   <= RD_WAIT;
        end
        RD_WAIT: begin
          rd_data  <= err_q ? '0 : mem_dout;
          rd_err   <= err_q;
          rd_valid <= 1'b1;
          err_q    <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_log_ctrl.sv
// Directed bench for result_log_ctrl with behavioural RAM models.
// Two instances: DEPTH=8 for the main flow, DEPTH=2 for wrap/full.
module tb_result_log_ctrl;

  logic        clk = 0;
  logic        reset;
  logic        wr_req, rd_req, clr;
  logic [31:0] wr_data;
  logic [7:0]  rd_index;
  logic        sel;

  logic        a_wr_ready, a_rd_ready, a_rd_valid, a_rd_err, a_full;
  logic        a_rw, a_mv;
  logic [31:0] a_rd_data, a_din, a_dout;
  logic [7:0]  a_addr;
  logic [8:0]  a_count;

  logic        b_wr_ready, b_rd_ready, b_rd_valid, b_rd_err, b_full;
  logic        b_rw, b_mv;
  logic [31:0] b_rd_data, b_din, b_dout;
  logic [1:0]  b_addr;
  logic [2:0]  b_count;

  logic [31:0] a_mem [256];
  logic [31:0] b_mem [4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  result_log_ctrl #(.WIDTH(32), .DEPTH(8)) dut_a (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_data(wr_data), .wr_ready(a_wr_ready),
    .rd_req(rd_req), .rd_index(rd_index), .rd_ready(a_rd_ready),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .rd_err(a_rd_err),
    .clr(clr), .count(a_count), .full(a_full),
    .mem_din(a_din), .mem_addr(a_addr), .mem_rw(a_rw),
    .mem_valid(a_mv), .mem_dout(a_dout)
  );

  result_log_ctrl #(.WIDTH(32), .DEPTH(2)) dut_b (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_data(wr_data), .wr_ready(b_wr_ready),
    .rd_req(rd_req), .rd_index(rd_index[1:0]), .rd_ready(b_rd_ready),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_err(b_rd_err),
    .clr(clr), .count(b_count), .full(b_full),
    .mem_din(b_din), .mem_addr(b_addr), .mem_rw(b_rw),
    .mem_valid(b_mv), .mem_dout(b_dout)
  );

  // Sync RAM: registered read, output register cleared when idle.
  always_ff @(posedge clk) begin
    if (a_mv && a_rw) a_mem[a_addr] <= a_din;
    a_dout <= (a_mv && !a_rw) ? a_mem[a_addr] : 32'd0;
    if (b_mv && b_rw) b_mem[b_addr] <= b_din;
    b_dout <= (b_mv && !b_rw) ? b_mem[b_addr] : 32'd0;
  end

  wire        o_wr_ready = sel ? b_wr_ready : a_wr_ready;
  wire        o_rd_ready = sel ? b_rd_ready : a_rd_ready;
  wire        o_rd_valid = sel ? b_rd_valid : a_rd_valid;
  wire        o_rd_err   = sel ? b_rd_err   : a_rd_err;
  wire        o_full     = sel ? b_full     : a_full;
  wire        o_rw       = sel ? b_rw       : a_rw;
  wire        o_mv       = sel ? b_mv       : a_mv;
  wire [31:0] o_rd_data  = sel ? b_rd_data  : a_rd_data;
  wire [31:0] o_din      = sel ? b_din      : a_din;
  wire [31:0] o_addr     = sel ? 32'(b_addr)  : 32'(a_addr);
  wire [31:0] o_count    = sel ? 32'(b_count) : 32'(a_count);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] d, input int addr,
                          input int cnt_after);
    wr_req  = 1;
    wr_data = d;
    #1;
    chk("wr_ready_idle", 32'(o_wr_ready), 1);
    tick();
    wr_req = 0;
    chk("wr_mv", 32'(o_mv), 1);
    chk("wr_rw", 32'(o_rw), 1);
    chk("wr_addr", o_addr, 32'(addr));
    chk("wr_din", o_din, d);
    chk("wr_ready_busy", 32'(o_wr_ready), 0);
    tick();
    chk("wr_mv_off", 32'(o_mv), 0);
    chk("wr_rw_off", 32'(o_rw), 0);
    chk("wr_ready_back", 32'(o_wr_ready), 1);
    chk("wr_count", o_count, 32'(cnt_after));
  endtask

  task automatic do_read(input int idx, input logic [31:0] exp_d,
                         input logic exp_e);
    rd_req   = 1;
    rd_index = 8'(idx);
    #1;
    chk("rd_ready_idle", 32'(o_rd_ready), 1);
    tick();
    rd_req = 0;
    chk("rd_mv_issue", 32'(o_mv), 32'(!exp_e));
    chk("rd_rw_issue", 32'(o_rw), 0);
    chk("rd_ready_busy", 32'(o_rd_ready), 0);
    tick();
    chk("rd_mv_wait", 32'(o_mv), 0);
    chk("rd_valid_early", 32'(o_rd_valid), 0);
    tick();
    chk("rd_valid", 32'(o_rd_valid), 1);
    chk("rd_data", o_rd_data, exp_d);
    chk("rd_err", 32'(o_rd_err), 32'(exp_e));
    tick();
    chk("rd_valid_drop", 32'(o_rd_valid), 0);
    chk("rd_err_drop", 32'(o_rd_err), 0);
    chk("rd_data_hold", o_rd_data, exp_d);
  endtask

  initial begin
    reset = 1; wr_req = 0; rd_req = 0; clr = 0;
    wr_data = 0; rd_index = 0; sel = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", o_count, 0);
    chk("rst_mv", 32'(o_mv), 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_din", o_din, 0);
    chk("rst_rd_valid", 32'(o_rd_valid), 0);
    chk("rst_rd_data", o_rd_data, 0);
    reset = 0;
    tick();

    // Three writes, then reads newest/oldest and out-of-range.
    do_write(32'h0000_000A, 0, 1);
    do_write(32'h0000_000B, 1, 2);
    do_write(32'h0000_000C, 2, 3);
    chk("full_3", 32'(o_full), 0);
    do_read(0, 32'h0000_000C, 0);
    do_read(2, 32'h0000_000A, 0);
    do_read(1, 32'h0000_000B, 0);
    do_read(5, 32'h0, 1);

    // clr beats write and read; next cycle write beats read.
    clr = 1; wr_req = 1; rd_req = 1; wr_data = 32'h55;
    #1;
    chk("clr_wr_ready", 32'(o_wr_ready), 0);
    chk("clr_rd_ready", 32'(o_rd_ready), 0);
    tick();
    chk("clr_count", o_count, 0);
    chk("clr_mv", 32'(o_mv), 0);
    clr = 0;
    #1;
    chk("both_wr_ready", 32'(o_wr_ready), 1);
    chk("both_rd_ready", 32'(o_rd_ready), 0);
    tick();
    wr_req = 0;
    chk("both_mv", 32'(o_mv), 1);
    chk("both_rw", 32'(o_rw), 1);
    chk("both_addr", o_addr, 0);
    chk("both_rd_ready_busy", 32'(o_rd_ready), 0);
    tick();
    chk("both_rd_ready_after", 32'(o_rd_ready), 1);
    chk("both_count", o_count, 1);
    rd_req = 0;
    do_read(0, 32'h55, 0);

    // Reset in RD_ISSUE aborts the read.
    rd_req = 1; rd_index = 0;
    tick();
    rd_req = 0;
    chk("abort_mv_pre", 32'(o_mv), 1);
    reset = 1;
    #1;
    chk("abort_mv", 32'(o_mv), 0);
    chk("abort_count", o_count, 0);
    tick();
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_valid", 32'(o_rd_valid), 0);
    end
    chk("abort_count_after", o_count, 0);

    // DEPTH=2 instance: wrap and saturate.
    sel = 1;
    chk("b_empty", o_count, 0);
    do_write(32'd1, 0, 1);
    do_write(32'd2, 1, 2);
    do_write(32'd3, 2, 3);
    chk("b_not_full", 32'(o_full), 0);
    do_write(32'd4, 3, 4);
    chk("b_full", 32'(o_full), 1);
    do_write(32'd5, 0, 4);
    chk("b_full_stays", 32'(o_full), 1);
    do_read(3, 32'd2, 0);
    do_read(0, 32'd5, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
